// File: rtl/cjb_mmio_pkg.sv
// Shared definitions for the cjbRISC memory-mapped I/O ports (input and LED output).
package cjb_mmio_pkg;

  // Default MMIO window base; each port decodes a few words above it.
  localparam logic [7:0] MMIO_BASE_ADDR = 8'hF0;

  // Register offsets of the input port.
  localparam int unsigned OFF_SW     = 0;
  localparam int unsigned OFF_STATUS = 1;
  localparam int unsigned OFF_PCNT   = 2;

  // STATUS register bit positions.
  localparam int unsigned ST_EVENT   = 0;
  localparam int unsigned ST_PRESSED = 1;

  // Which register a CPU read selects.
  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_SW     = 2'd1,
    SEL_STATUS = 2'd2,
    SEL_PCNT   = 2'd3
  } reg_sel_e;

  // Map a register offset (address minus base) onto a register select.
  function automatic reg_sel_e decode_offset(input logic [7:0] off);
    case (off)
      8'(OFF_SW):     decode_offset = SEL_SW;
      8'(OFF_STATUS): decode_offset = SEL_STATUS;
      8'(OFF_PCNT):   decode_offset = SEL_PCNT;
      default:        decode_offset = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cjb_mmio_input_port_if.sv
// CPU-side MMIO read bus: single-cycle read strobe, response registered one cycle later.
interface cjb_mmio_input_port_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              MemRd;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] RdData;
  logic              RdValid;

  // CPU issues reads and consumes responses.
  modport master (output MemRd, output Addr, input RdData, input RdValid);
  // Peripheral decodes reads and returns data.
  modport slave  (input MemRd, input Addr, output RdData, output RdValid);
endinterface

// File: rtl/cjb_debounce.sv
// Two-flop synchroniser plus stability counter for one active-low pushbutton pin.
// level is the accepted (clean) level; level_nxt is the value level takes at the next edge,
// exposed so the parent can detect an accepted transition in the same cycle it happens.
module cjb_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic pin,
  output logic level,
  output logic level_nxt
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Count consecutive samples that differ from the accepted level; accept after DB_CYCLES of them.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    level_nxt = level;
    cnt_nxt   = '0;
    if (sync[1] != level) begin
      if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        level_nxt = sync[1];
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // Synchroniser shift and debounce state, cleared by synchronous reset.
  always_ff @(posedge Clock) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], pin};
      level <= level_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/cjb_mmio_input_port.sv
// MMIO input port: synchronised switches, debounced PB1 with sticky press event and
// 8-bit press counter, and a registered read port at BASE+0/1/2.
module cjb_mmio_input_port
  import cjb_mmio_pkg::*;
#(
  parameter int              ADDR_W    = 8,
  parameter int              DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(MMIO_BASE_ADDR),
  parameter int              DB_CYCLES = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    PB1,
  input  logic [3:0]              SW,
  cjb_mmio_input_port_if.slave    bus,
  output logic                    PressIrq
);

  logic [3:0]        sw_meta;
  logic [3:0]        sw_q;
  logic              db_level;
  logic              db_level_nxt;
  logic              press;
  logic              press_event;
  logic [7:0]        press_cnt;
  logic [ADDR_W-1:0] offset;
  reg_sel_e          sel;
  logic [DATA_W-1:0] rd_next;
  logic              status_rd;

  cjb_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db (
    .Clock     (Clock),
    .Reset     (Reset),
    .pin       (PB1),
    .level     (db_level),
    .level_nxt (db_level_nxt)
  );

  // Accepted press: debounced level about to fall from released to pressed.
  assign press = db_level & ~db_level_nxt;

  // Two-flop synchroniser for the switch bank.
  always_ff @(posedge Clock) begin
    // NOTE: reset here is synchronous and active-high; it is just another D-input condition.
    if (Reset) begin
      sw_meta <= '0;
      sw_q    <= '0;
    end else begin
      sw_meta <= SW;
      sw_q    <= sw_meta;
    end
  end

  // Address decode and read-data mux for the response registered at the next edge.
  always_comb begin
    offset    = bus.Addr - BASE_ADDR;
    sel       = SEL_NONE;
    rd_next   = '0;
    status_rd = 1'b0;
    if (bus.MemRd && (offset < ADDR_W'(8'hFF))) begin
      sel = decode_offset(8'(offset));
    end
    case (sel)
      SEL_SW:     rd_next[3:0] = sw_q;
      SEL_STATUS: begin
        rd_next[ST_PRESSED] = ~db_level;
        rd_next[ST_EVENT]   = press_event;
        status_rd           = 1'b1;
      end
      SEL_PCNT:   rd_next[7:0] = press_cnt;
      default:    rd_next      = '0;
    endcase
  end

  // Read response register, sticky press event (set wins over clear-on-read) and press counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bus.RdData  <= '0;
      bus.RdValid <= 1'b0;
      press_event <= 1'b0;
      press_cnt   <= '0;
    end else begin
      bus.RdData  <= rd_next;
      bus.RdValid <= (sel != SEL_NONE);
      if (press) begin
        press_event <= 1'b1;
      end else if (status_rd) begin
        press_event <= 1'b0;
      end
      if (press) begin
        press_cnt <= press_cnt + 8'd1;
      end
    end
  end

  assign PressIrq = press_event;

endmodule

// File: tb/tb_cjb_mmio_input_port.sv
// Self-checking bench for cjb_mmio_input_port: directed vector table, hand-written corner
// sequences and randomised traffic, all compared every cycle against a behavioural model.
module tb_cjb_mmio_input_port;

  localparam int DB = 4;

  logic       clk;
  logic       rst;
  logic       pb1;
  logic [3:0] sw;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;

  cjb_mmio_input_port_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  cjb_mmio_input_port #(
    .ADDR_W    (8),
    .DATA_W    (16),
    .BASE_ADDR (8'hF0),
    .DB_CYCLES (DB)
  ) dut (
    .Clock    (clk),
    .Reset    (rst),
    .PB1      (pb1),
    .SW       (sw),
    .bus      (bus),
    .PressIrq (irq)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  // Behavioural model: pins reach the logic two clocks late; a new button level is accepted
  // once the last DB synchronised samples all disagree with the current level.
  logic        m_pin_d1, m_pin_d2;
  logic [3:0]  m_sw_d1, m_sw_d2;
  logic        m_hist [DB];
  logic        m_level;
  logic        m_event;
  logic [7:0]  m_pcnt;
  logic [15:0] m_rdata;
  logic        m_rvalid;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic p, input logic [3:0] s, input logic rd,
                            input logic [7:0] a, input logic r);
    logic all_differ;
    logic pressed_now;
    logic stat;
    if (r) begin
      m_pin_d1 = 1'b1; m_pin_d2 = 1'b1;
      m_sw_d1  = '0;   m_sw_d2  = '0;
      for (int i = 0; i < DB; i++) m_hist[i] = 1'b1;
      m_level = 1'b1; m_event = 1'b0; m_pcnt = '0;
      m_rdata = '0;   m_rvalid = 1'b0;
    end else begin
      for (int i = DB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_pin_d2;
      all_differ = 1'b1;
      for (int i = 0; i < DB; i++) if (m_hist[i] == m_level) all_differ = 1'b0;
      pressed_now = all_differ && m_level;
      m_rdata = '0; m_rvalid = 1'b0; stat = 1'b0;
      if (rd) begin
        case (a)
          8'hF0: begin m_rvalid = 1'b1; m_rdata = {12'd0, m_sw_d2}; end
          8'hF1: begin m_rvalid = 1'b1; m_rdata = {14'd0, ~m_level, m_event}; stat = 1'b1; end
          8'hF2: begin m_rvalid = 1'b1; m_rdata = {8'd0, m_pcnt}; end
          default: ;
        endcase
      end
      if (all_differ) m_level = ~m_level;
      if (pressed_now) m_event = 1'b1;
      else if (stat) m_event = 1'b0;
      if (pressed_now) m_pcnt = m_pcnt + 8'd1;
      m_pin_d2 = m_pin_d1; m_pin_d1 = p;
      m_sw_d2  = m_sw_d1;  m_sw_d1  = s;
    end
  endtask

  // One clock: drive at negedge, model the rising edge, compare at the following negedge.
  task automatic tick(input logic p, input logic [3:0] s, input logic rd,
                      input logic [7:0] a, input logic r);
    pb1 = p; sw = s; bus.MemRd = rd; bus.Addr = a; rst = r;
    @(posedge clk);
    model_step(p, s, rd, a, r);
    @(negedge clk);
    check("cycle", {13'd0, bus.RdValid, irq, bus.RdData}, {13'd0, m_rvalid, m_event, m_rdata});
  endtask

  task automatic idle(input logic p, input int n);
    for (int i = 0; i < n; i++) tick(p, 4'h0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic read(input logic p, input logic [7:0] a);
    tick(p, 4'h0, 1'b1, a, 1'b0);
  endtask

  task automatic press_once();
    idle(1'b0, 6);
    idle(1'b1, 6);
  endtask

  typedef struct {
    logic        pb;
    logic [3:0]  sw;
    logic        rd;
    logic [7:0]  addr;
    logic        exp_v;
    logic [15:0] exp_d;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int irq_at;
    int hold;
    logic p_rand;

    vecs[0] = '{1'b1, 4'h0, 1'b1, 8'hF0, 1'b1, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 4'h0, 1'b1, 8'hF1, 1'b1, 16'h0000, 1'b0};
    vecs[2] = '{1'b1, 4'h0, 1'b1, 8'hF2, 1'b1, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 4'h0, 1'b0, 8'hF0, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{1'b1, 4'h0, 1'b1, 8'hF3, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 4'hF, 1'b0, 8'hF0, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{1'b1, 4'hF, 1'b1, 8'hF0, 1'b1, 16'h0000, 1'b0};
    vecs[7] = '{1'b1, 4'hF, 1'b1, 8'hF0, 1'b1, 16'h000F, 1'b0};
    vecs[8] = '{1'b1, 4'hF, 1'b1, 8'hE0, 1'b0, 16'h0000, 1'b0};

    pb1 = 1'b1; sw = '0; bus.MemRd = 1'b0; bus.Addr = '0; rst = 1'b1;
    @(negedge clk);

    // Reset for five cycles.
    for (int i = 0; i < 5; i++) tick(1'b1, 4'h0, 1'b0, 8'h00, 1'b1);
    check("reset_rdvalid", {31'd0, bus.RdValid}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);

    // Directed vector table: reset-value reads, miss, switch latency.
    for (int i = 0; i < 9; i++) begin
      tick(vecs[i].pb, vecs[i].sw, vecs[i].rd, vecs[i].addr, 1'b0);
      check($sformatf("vec%0d", i), {14'd0, bus.RdValid, irq, bus.RdData},
            {14'd0, vecs[i].exp_v, vecs[i].exp_irq, vecs[i].exp_d});
    end

    // Two-cycle glitch is rejected.
    idle(1'b0, 2);
    idle(1'b1, 6);
    check("glitch_irq", {31'd0, irq}, 32'd0);
    read(1'b1, 8'hF2);
    check("glitch_pcnt", {16'd0, bus.RdData}, 32'h0000);

    // Held press: event within 2+4 cycles, clear-on-read, release does not count.
    irq_at = 0;
    for (int i = 1; i <= 10; i++) begin
      idle(1'b0, 1);
      if (irq && irq_at == 0) irq_at = i;
    end
    check("press_latency", {31'd0, (irq_at >= 1 && irq_at <= 6)}, 32'd1);
    read(1'b0, 8'hF1);
    check("status_first", {16'd0, bus.RdData}, 32'h0003);
    read(1'b0, 8'hF1);
    check("status_second", {16'd0, bus.RdData}, 32'h0002);
    idle(1'b1, 8);
    read(1'b1, 8'hF2);
    check("pcnt_one", {16'd0, bus.RdData}, 32'h0001);
    read(1'b1, 8'hF1);
    check("status_released", {16'd0, bus.RdData}, 32'h0000);

    // Press accepted on the same edge as a STATUS read: old value returned, event stays set.
    idle(1'b0, 5);
    read(1'b0, 8'hF1);
    check("coincide_data", {16'd0, bus.RdData}, 32'h0000);
    check("coincide_irq", {31'd0, irq}, 32'd1);
    read(1'b0, 8'hF1);
    check("coincide_after", {16'd0, bus.RdData}, 32'h0003);
    idle(1'b1, 8);
    read(1'b1, 8'hF2);
    check("pcnt_two", {16'd0, bus.RdData}, 32'h0002);

    // Reset mid-debounce and mid-read discards everything.
    idle(1'b0, 3);
    tick(1'b0, 4'h0, 1'b1, 8'hF2, 1'b1);
    tick(1'b1, 4'h0, 1'b0, 8'h00, 1'b1);
    check("midrst_rdvalid", {31'd0, bus.RdValid}, 32'd0);
    idle(1'b1, 6);
    read(1'b1, 8'hF2);
    check("midrst_pcnt", {16'd0, bus.RdData}, 32'h0000);
    read(1'b1, 8'hF1);
    check("midrst_status", {16'd0, bus.RdData}, 32'h0000);
    check("midrst_irq", {31'd0, irq}, 32'd0);

    // Press counter wrap after 256 presses.
    for (int i = 0; i < 255; i++) press_once();
    read(1'b1, 8'hF2);
    check("pcnt_255", {16'd0, bus.RdData}, 32'h00FF);
    press_once();
    read(1'b1, 8'hF2);
    check("pcnt_wrap", {16'd0, bus.RdData}, 32'h0000);

    // Randomised traffic against the model, back-to-back reads included.
    p_rand = 1'b1;
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] a;
      if (hold == 0) begin
        p_rand = ~p_rand;
        hold = $urandom_range(1, 9);
      end
      hold--;
      case ($urandom_range(0, 4))
        0: a = 8'hF0;
        1: a = 8'hF1;
        2: a = 8'hF2;
        3: a = 8'hF3;
        default: a = 8'($urandom);
      endcase
      tick(p_rand, 4'($urandom), 1'($urandom), a, ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
